imm_extend_unit: RTL
====================

# imm_extend_unit

Parametrised, sequential successor to the 8-to-16 zero extender in the processor datapath. It assembles an immediate from one or more IN_W-bit chunks, most significant chunk first, and zero- or sign-extends the result to OUT_W bits. The result is presented through a registered valid/ready output. It sits between instruction decode and the ALU-B operand mux, and supports multi-instruction immediates (upper/lower loads) as well as single-chunk extension.

## Interface
Parameters:
- IN_W, 8, chunk width in bits; must be at least 1 and at most OUT_W.
- OUT_W, 16, result width in bits.

Ports:
- clk, input, 1, the single clock; all state updates on the rising edge.
- rst_n, input, 1, asynchronous active-low reset.
- in_valid, input, 1, a chunk is presented.
- in_ready, output, 1, the unit can accept a chunk; a chunk transfers when in_valid && in_ready.
- in_data, input, IN_W, chunk bits.
- in_last, input, 1, the presented chunk is the final chunk of this immediate.
- in_sign, input, 1, extension mode: 0 = zero-extend, 1 = sign-extend; sampled only on the last chunk.
- out_valid, output, 1, out_data holds a completed immediate.
- out_ready, input, 1, the consumer accepts out_data.
- out_data, output, OUT_W, extended immediate.
- out_ovf, output, 1, present only when IMM_EXT_OVF_EN is defined.

## Operation
- MAX_CHUNKS = ceil(OUT_W/IN_W).
- acc is an OUT_W-bit accumulator.
- cnt counts chunks already accumulated; it is clog2(MAX_CHUNKS+1) bits wide and saturates at MAX_CHUNKS.

On an accepted chunk with in_last=0:
- acc <= (acc << IN_W) | in_data, truncated to OUT_W bits.
- cnt <= cnt+1, saturating.

On an accepted chunk with in_last=1:
- Form raw = (acc << IN_W) | in_data, truncated to OUT_W bits.
- nbits = min((cnt+1)*IN_W, OUT_W).
- Bits [OUT_W-1:nbits] of out_data are filled with 0 when in_sign=0, or with raw[nbits-1] when in_sign=1.
- out_valid <= 1.
- acc and cnt are cleared to 0.

Output holding:
- out_data and out_valid hold until out_valid && out_ready.
- If no new last chunk arrives in that cycle, out_valid then clears.
- out_data keeps its last value after out_valid clears.

Flow control:
- in_ready = !out_valid || out_ready.
- In the drain cycle, a new chunk (last or not) is accepted in the same cycle as the output transfer.
- If that chunk is a last chunk, out_valid stays 1 and out_data takes the new result.

Overflow:
- An immediate overflows when it has more than MAX_CHUNKS chunks.
- Without IMM_EXT_OVF_EN, excess upper bits shift out silently; the low OUT_W bits are kept.

## Timing
- Reset values: out_valid=0, out_data=0, out_ovf=0, acc=0, cnt=0, overflow-pending=0. in_ready therefore reads 1 after reset.
- Latency: out_valid rises 1 cycle after the last chunk is accepted. Nothing is combinational from in_data to out_data.
- Throughput: one chunk per cycle. Single-chunk immediates complete one per cycle while out_ready=1.
- States:
  - ACCUM (cnt==0): out_valid may be 0 or 1.
  - PARTIAL (cnt>0): out_valid may be 0 or 1.
  - Transitions are driven only by accepted chunks and by output drains. The two event types are independent and may happen in the same cycle.
- Reset asserted mid-accumulation discards the partial acc and any pending output immediately, without waiting for a clock edge.
- in_valid=0 for any number of cycles in PARTIAL preserves acc and cnt.
- A chunk whose in_data width is exactly OUT_W (IN_W == OUT_W) gives nbits=OUT_W, so no extension is applied.

## Configuration
- IMM_EXT_OVF_EN defined:
  - Adds the out_ovf port and a sticky overflow-pending bit.
  - The bit is set when a chunk is accepted with cnt==MAX_CHUNKS.
  - out_ovf is registered alongside out_data on the last chunk, including when the last chunk itself overflows.
  - The pending bit is cleared on the last chunk.
- IMM_EXT_OVF_EN undefined:
  - No out_ovf port and no pending bit.
  - Overflow truncates silently.

## Structure
- The shared processor package holds:
  - The extension-mode constants EXT_ZERO=1'b0 and EXT_SIGN=1'b1.
  - The defaults IMM_IN_W=8 and IMM_OUT_W=16.
- One sub-module, imm_ext_fill, is natural. It is a combinational fill with ports raw, nbits and sign, producing the extended word. It replaces the old fixed zero extender at all call sites that use IN_W=8, OUT_W=16.
- The accumulator, counter and output register live in imm_extend_unit.

## Test plan
All scenarios use IN_W=8, OUT_W=16.
- Single chunk 0x85 with in_last=1, in_sign=0 -> next cycle out_valid=1, out_data=0x0085.
- Single chunk 0x85 with in_last=1, in_sign=1 -> out_data=0xFF85. Then 0x7F with sign=1 -> 0x007F.
- Chunk 0x92 (in_last=0), then 0x34 (in_last=1, sign=1) -> out_data=0x9234, with no sign fill because nbits=16.
- Backpressure:
  - Result held with out_ready=0 while chunk 0x11 (last) is presented -> in_ready=0 and out_data unchanged.
  - Then raise out_ready -> old result transfers and 0x11 is accepted in the same cycle; next cycle out_data=0x0011.
- Overflow: chunks 0xAA, 0xBB, then 0xCC (last) -> out_data=0xBBCC. out_ovf=1 when IMM_EXT_OVF_EN is defined; the following immediate gives out_ovf=0.
- Reset mid-operation:
  - Accept 0x12 with in_last=0, then pulse rst_n low between clock edges -> out_valid=0 immediately and acc cleared.
  - Then 0x05 (last, zero) -> out_data=0x0005.

Source files
------------

// File: rtl/imm_extend_unit_pkg.sv
// imm_extend_unit_pkg: extension-mode constants and default widths for the immediate extender
package imm_extend_unit_pkg;
  localparam logic EXT_ZERO = 1'b0;
  localparam logic EXT_SIGN = 1'b1;
  localparam int IMM_IN_W = 8;
  localparam int IMM_OUT_W = 16;
  function automatic int max_chunks(input int in_w, input int out_w);
    return (out_w + in_w - 1) / in_w;
  endfunction
endpackage

// File: rtl/imm_extend_unit_if.sv
// imm_extend_unit_if: chunk input and result output streams; out_ovf exists only with IMM_EXT_OVF_EN
interface imm_extend_unit_if import imm_extend_unit_pkg::*; #(
  parameter int IN_W = IMM_IN_W,
  parameter int OUT_W = IMM_OUT_W
);
  logic in_valid;
  logic in_ready;
  logic [IN_W-1:0] in_data;
  logic in_last;
  logic in_sign;
  logic out_valid;
  logic out_ready;
  logic [OUT_W-1:0] out_data;
`ifdef IMM_EXT_OVF_EN
  logic out_ovf;
  modport master (output in_valid, in_data, in_last, in_sign, out_ready, input in_ready, out_valid, out_data, out_ovf);
  modport slave (input in_valid, in_data, in_last, in_sign, out_ready, output in_ready, out_valid, out_data, out_ovf);
`else
  modport master (output in_valid, in_data, in_last, in_sign, out_ready, input in_ready, out_valid, out_data);
  modport slave (input in_valid, in_data, in_last, in_sign, out_ready, output in_ready, out_valid, out_data);
`endif
endinterface

// File: rtl/imm_ext_fill.sv
// imm_ext_fill: keeps the low nbits of raw and fills the rest with zero or the bit at nbits-1
module imm_ext_fill import imm_extend_unit_pkg::*; #(
  parameter int OUT_W = IMM_OUT_W,
  parameter int NW = $clog2(OUT_W + 1)
) (
  input  logic [OUT_W-1:0] raw,
  input  logic [NW-1:0]    nbits,
  input  logic             sign,
  output logic [OUT_W-1:0] ext
);
  logic [OUT_W-1:0] mask;
  logic fill;
  assign mask = ~({OUT_W{1'b1}} << nbits);
  assign fill = (sign == EXT_SIGN) && |(raw & (mask ^ (mask >> 1)));
  assign ext = (raw & mask) | ({OUT_W{fill}} & ~mask);
endmodule

// File: rtl/imm_extend_unit.sv
// imm_extend_unit: assembles MSB-first chunks into an extended immediate with registered valid/ready output; IMM_EXT_OVF_EN adds out_ovf
module imm_extend_unit import imm_extend_unit_pkg::*; #(
  parameter int IN_W = IMM_IN_W,
  parameter int OUT_W = IMM_OUT_W
) (
  input logic clk,
  input logic rst_n,
  imm_extend_unit_if.slave bus
);
  localparam int MAXC = max_chunks(IN_W, OUT_W);
  localparam int CW = $clog2(MAXC + 1);
  localparam int NW = $clog2(OUT_W + 1);
  logic [OUT_W-1:0] acc_q, acc_d, out_data_q, out_data_d, raw, ext;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [NW-1:0] nbits;
  logic [31:0] span;
  logic out_valid_q, out_valid_d, take, done, drain, full;
  assign raw = OUT_W'({acc_q, bus.in_data});
  assign span = (32'(cnt_q) + 32'd1) * 32'(IN_W);
  assign nbits = span > 32'(OUT_W) ? NW'(OUT_W) : NW'(span);
  assign full = cnt_q == CW'(MAXC);
  assign bus.in_ready = !out_valid_q || bus.out_ready;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data = out_data_q;
  assign take = bus.in_valid && bus.in_ready;
  assign done = take && bus.in_last;
  assign drain = out_valid_q && bus.out_ready;
  imm_ext_fill #(.OUT_W(OUT_W), .NW(NW)) u_fill (.raw(raw), .nbits(nbits), .sign(bus.in_sign), .ext(ext));
  // next state: accumulate on non-last chunks, publish and clear on the last one
  always_comb begin
    acc_d = take ? (bus.in_last ? '0 : raw) : acc_q;
    cnt_d = take ? (bus.in_last ? '0 : cnt_q + CW'(!full)) : cnt_q;
    out_valid_d = done || (out_valid_q && !drain);
    out_data_d = done ? ext : out_data_q;
  end
  // state registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q <= '0;
      cnt_q <= '0;
      out_valid_q <= 1'b0;
      out_data_q <= '0;
    end else begin
      acc_q <= acc_d;
      cnt_q <= cnt_d;
      out_valid_q <= out_valid_d;
      out_data_q <= out_data_d;
    end
  end
`ifdef IMM_EXT_OVF_EN
  logic ovf_pend_q, ovf_pend_d, out_ovf_q, out_ovf_d, hit;
  assign hit = take && full;
  assign bus.out_ovf = out_ovf_q;
  // overflow is sticky across the immediate and reported with its result
  always_comb begin
    ovf_pend_d = !done && (ovf_pend_q || hit);
    out_ovf_d = done ? (ovf_pend_q || hit) : out_ovf_q;
  end
  // overflow registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_pend_q <= 1'b0;
      out_ovf_q <= 1'b0;
    end else begin
      ovf_pend_q <= ovf_pend_d;
      out_ovf_q <= out_ovf_d;
    end
  end
`endif
endmodule
